// File: rtl/s2_pkg.sv
// Shared constants and FSM state type for the S2 serial receive path.
package s2_pkg;

  localparam int FRAME_BITS = 21;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 18;
  localparam int NUM_WORDS  = 8;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } s2_state_t;

endpackage

// File: rtl/s2_shift_rx.sv
// Serial-in shift register with a saturating bit counter.
// A clear with shift_en high starts a fresh frame holding the current bit.
module s2_shift_rx #(
  parameter int FRAME_BITS = s2_pkg::FRAME_BITS,
  parameter int CNT_W      = $clog2(FRAME_BITS + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic                  sd,
  output logic [FRAME_BITS-1:0] shreg,
  output logic [CNT_W-1:0]      count
);
  import s2_pkg::*;

  // Saturating one past a full frame lets long frames be told apart from exact ones.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= shift_en ? {{(FRAME_BITS-1){1'b0}}, sd} : '0;
      count <= shift_en ? CNT_W'(1) : '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_BITS-2:0], sd};
      if (count != CNT_MAX) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2_serial_receiver.sv
// S2 receive side: deserializes sen/sd frames into RB2 writes and flags completion.
// Optional frame length checking is enabled by defining S2_FRAME_CHECK_EN.
module s2_serial_receiver #(
  parameter int FRAME_BITS = s2_pkg::FRAME_BITS,
  parameter int ADDR_W     = s2_pkg::ADDR_W,
  parameter int DATA_W     = s2_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              S2_done,
  output logic              frame_err
);
  import s2_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  s2_state_t             state, state_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      count;
  logic [NUM_WORDS-1:0]  mask, mask_next;
  logic                  shift_en, clear, frame_end, len_ok, write_go;

  s2_shift_rx #(
    .FRAME_BITS(FRAME_BITS),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .clear   (clear),
    .sd      (sd),
    .shreg   (shreg),
    .count   (count)
  );

`ifdef S2_FRAME_CHECK_EN
  assign len_ok = (count == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_end && !len_ok;
    end
  end
`else
  logic count_unused;

  assign len_ok       = 1'b1;
  assign count_unused = ^count;
  assign frame_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  // The counter is held clear outside SHIFT, so a low sen in IDLE or WRITE starts a frame at count 1.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    clear      = 1'b1;
    frame_end  = 1'b0;
    mask_next  = mask | (NUM_WORDS'(1) << RB2_A);
    case (state)
      ARM: begin
        if (sen) state_next = IDLE;
      end
      IDLE: begin
        shift_en = !sen;
        if (!sen) state_next = SHIFT;
      end
      SHIFT: begin
        clear    = 1'b0;
        shift_en = !sen;
        if (sen) begin
          frame_end  = 1'b1;
          state_next = len_ok ? WRITE : IDLE;
        end
      end
      WRITE: begin
        shift_en = !sen;
        if (&mask_next)  state_next = DONE;
        else if (!sen)   state_next = SHIFT;
        else             state_next = IDLE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = ARM;
    endcase
    write_go = frame_end && len_ok;
  end

  // RB2 outputs are loaded as the FSM enters WRITE so the strobe lines up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RB2_RW  <= 1'b1;
      RB2_A   <= '0;
      RB2_D   <= '0;
      mask    <= '0;
      S2_done <= 1'b0;
    end else begin
      RB2_RW <= !write_go;
      if (write_go) begin
        RB2_A <= shreg[FRAME_BITS-1 -: ADDR_W];
        RB2_D <= shreg[DATA_W-1:0];
      end
      if (state == WRITE) begin
        mask <= mask_next;
        if (&mask_next) S2_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s2_serial_receiver.sv
// Directed self-checking bench for s2_serial_receiver; the short-frame scenario
// expects a rejected frame when S2_FRAME_CHECK_EN is defined, a zero-filled write otherwise.
module tb_s2_serial_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        sen;
  logic        sd;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic        S2_done;
  logic        frame_err;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]  wr_a_q[$];
  logic [17:0] wr_d_q[$];

  s2_serial_receiver dut (
    .clk      (clk),
    .rst      (rst),
    .sen      (sen),
    .sd       (sd),
    .RB2_RW   (RB2_RW),
    .RB2_A    (RB2_A),
    .RB2_D    (RB2_D),
    .S2_done  (S2_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Log every cycle in which the write strobe is active.
  always @(negedge clk) begin
    if (rst === 1'b0 && RB2_RW === 1'b0) begin
      wr_a_q.push_back(RB2_A);
      wr_d_q.push_back(RB2_D);
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_bits(input int nbits, input logic [20:0] frame);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = frame[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    sen = 1'b1;
    sd  = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [17:0] d);
    drive_bits(21, {a, d});
    end_frame();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b1;
    sd  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr_a_q.delete();
    wr_d_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b0;
    sd  = 1'b1;
    settle(2);
    n_vec++; if (RB2_RW !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rw: got %b want 1", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd0) begin n_err++; $display("[TB] FAIL reset_a: got %0d want 0", RB2_A); end
    n_vec++; if (RB2_D !== 18'h0) begin n_err++; $display("[TB] FAIL reset_d: got %h want 0", RB2_D); end
    n_vec++; if (S2_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", S2_done); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_single_write();
    do_reset();
    send_frame(3'b101, 18'h2A5C3);
    #1;
    n_vec++; if (RB2_RW !== 1'b1) begin n_err++; $display("[TB] FAIL single_early: got rw=%b want 1", RB2_RW); end
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL single_rw: got %b want 0", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd5) begin n_err++; $display("[TB] FAIL single_a: got %0d want 5", RB2_A); end
    n_vec++; if (RB2_D !== 18'h2A5C3) begin n_err++; $display("[TB] FAIL single_d: got %h want 2a5c3", RB2_D); end
    settle(1);
    n_vec++; if (RB2_RW !== 1'b1) begin n_err++; $display("[TB] FAIL single_rw_after: got %b want 1", RB2_RW); end
    n_vec++; if (RB2_D !== 18'h2A5C3) begin n_err++; $display("[TB] FAIL single_d_hold: got %h want 2a5c3", RB2_D); end
    settle(3);
    n_vec++; if (wr_a_q.size() !== 1) begin n_err++; $display("[TB] FAIL single_count: got %0d writes want 1", wr_a_q.size()); end
  endtask

  task automatic test_eight_frames();
    logic [17:0] exp_d;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      send_frame(3'(a), 18'h00001 << a);
    end
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL eight_last_rw: got %b want 0", RB2_RW); end
    n_vec++; if (S2_done !== 1'b0) begin n_err++; $display("[TB] FAIL eight_done_early: got %b want 0", S2_done); end
    settle(1);
    n_vec++; if (S2_done !== 1'b1) begin n_err++; $display("[TB] FAIL eight_done: got %b want 1", S2_done); end
    n_vec++; if (wr_a_q.size() !== 8) begin n_err++; $display("[TB] FAIL eight_count: got %0d writes want 8", wr_a_q.size()); end
    for (int i = 0; i < 8 && i < wr_a_q.size(); i++) begin
      exp_d = 18'h00001 << i;
      n_vec++; if (wr_a_q[i] !== 3'(i)) begin n_err++; $display("[TB] FAIL eight_a%0d: got %0d want %0d", i, wr_a_q[i], i); end
      n_vec++; if (wr_d_q[i] !== exp_d) begin n_err++; $display("[TB] FAIL eight_d%0d: got %h want %h", i, wr_d_q[i], exp_d); end
    end
    send_frame(3'd3, 18'h3AAAA);
    settle(3);
    n_vec++; if (wr_a_q.size() !== 8) begin n_err++; $display("[TB] FAIL ninth_ignored: got %0d writes want 8", wr_a_q.size()); end
    n_vec++; if (S2_done !== 1'b1) begin n_err++; $display("[TB] FAIL done_sticky: got %b want 1", S2_done); end
  endtask

  task automatic test_duplicate();
    do_reset();
    send_frame(3'd2, 18'h3FFFF);
    for (int a = 0; a < 7; a++) begin
      if (a != 2) send_frame(3'(a), 18'h00100 + 18'(a));
    end
    send_frame(3'd2, 18'h00000);
    settle(2);
    n_vec++; if (S2_done !== 1'b0) begin n_err++; $display("[TB] FAIL dup_done_early: got %b want 0", S2_done); end
    n_vec++; if (RB2_A !== 3'd2) begin n_err++; $display("[TB] FAIL dup_a: got %0d want 2", RB2_A); end
    n_vec++; if (RB2_D !== 18'h0) begin n_err++; $display("[TB] FAIL dup_d: got %h want 0", RB2_D); end
    send_frame(3'd7, 18'h00107);
    settle(2);
    n_vec++; if (S2_done !== 1'b1) begin n_err++; $display("[TB] FAIL dup_done: got %b want 1", S2_done); end
    n_vec++; if (wr_a_q.size() !== 9) begin n_err++; $display("[TB] FAIL dup_count: got %0d writes want 9", wr_a_q.size()); end
  endtask

  task automatic test_short_frame();
    do_reset();
    drive_bits(15, 21'h05A3C);
    end_frame();
`ifdef S2_FRAME_CHECK_EN
    settle(1);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("[TB] FAIL short_ferr: got %b want 1", frame_err); end
    n_vec++; if (RB2_RW !== 1'b1) begin n_err++; $display("[TB] FAIL short_nowrite: got rw=%b want 1", RB2_RW); end
    settle(1);
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL short_ferr_pulse: got %b want 0", frame_err); end
`else
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL short_rw: got %b want 0", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd0) begin n_err++; $display("[TB] FAIL short_a: got %0d want 0", RB2_A); end
    n_vec++; if (RB2_D !== 18'h05A3C) begin n_err++; $display("[TB] FAIL short_d: got %h want 05a3c", RB2_D); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL short_ferr: got %b want 0", frame_err); end
`endif
    send_frame(3'd1, 18'h15555);
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL after_short_rw: got %b want 0", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd1) begin n_err++; $display("[TB] FAIL after_short_a: got %0d want 1", RB2_A); end
    n_vec++; if (RB2_D !== 18'h15555) begin n_err++; $display("[TB] FAIL after_short_d: got %h want 15555", RB2_D); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sd = i[0];
    end
    rst = 1'b0;
    wr_a_q.delete();
    wr_d_q.delete();
    drive_bits(10, 21'h00155);
    end_frame();
    settle(3);
    n_vec++; if (wr_a_q.size() !== 0) begin n_err++; $display("[TB] FAIL partial_nowrite: got %0d writes want 0", wr_a_q.size()); end
    send_frame(3'd6, 18'h12345);
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL partial_next_rw: got %b want 0", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd6) begin n_err++; $display("[TB] FAIL partial_next_a: got %0d want 6", RB2_A); end
    n_vec++; if (RB2_D !== 18'h12345) begin n_err++; $display("[TB] FAIL partial_next_d: got %h want 12345", RB2_D); end
  endtask

  task automatic test_reset_during_shift();
    do_reset();
    send_frame(3'd7, 18'h2BEEF);
    drive_bits(10, {3'd4, 18'h3C3C3});
    @(negedge clk);
    rst = 1'b1;
    settle(1);
    n_vec++; if (RB2_A !== 3'd0) begin n_err++; $display("[TB] FAIL midrst_a: got %0d want 0", RB2_A); end
    n_vec++; if (RB2_D !== 18'h0) begin n_err++; $display("[TB] FAIL midrst_d: got %h want 0", RB2_D); end
    n_vec++; if (RB2_RW !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_rw: got %b want 1", RB2_RW); end
    sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle(3);
    n_vec++; if (wr_a_q.size() !== 1) begin n_err++; $display("[TB] FAIL midrst_nowrite: got %0d writes want 1", wr_a_q.size()); end
    send_frame(3'd3, 18'h1F0F0);
    settle(1);
    n_vec++; if (RB2_RW !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_next_rw: got %b want 0", RB2_RW); end
    n_vec++; if (RB2_A !== 3'd3) begin n_err++; $display("[TB] FAIL midrst_next_a: got %0d want 3", RB2_A); end
    n_vec++; if (RB2_D !== 18'h1F0F0) begin n_err++; $display("[TB] FAIL midrst_next_d: got %h want 1f0f0", RB2_D); end
  endtask

  initial begin
    rst = 1'b1;
    sen = 1'b1;
    sd  = 1'b0;
    test_reset();
    test_single_write();
    test_eight_frames();
    test_duplicate();
    test_short_frame();
    test_reset_mid_frame();
    test_reset_during_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s2_serial_receiver.md
# s2_serial_receiver

Receive side of the S1→S2 serial link. Samples the `sen`/`sd` serial frames and deserializes each one into a 3-bit address and 18-bit word. Writes the word into result buffer RB2 through a single-cycle write strobe. Asserts `S2_done` once all eight RB2 addresses have been written.

## Interface
- `FRAME_BITS`, default 21: serial frame length, 3 address bits plus 18 data bits.
- `ADDR_W`, default 3: RB2 address width.
- `DATA_W`, default 18: RB2 data width.
- `clk` in 1: system clock. Serial inputs are sampled on its rising edge; the transmitter drives them on the falling edge.
- `rst` in 1: reset, asynchronous, active-high.
- `sen` in 1: frame enable, active-low. Low for the duration of a frame, high for at least one cycle between frames.
- `sd` in 1: serial data, MSB first. Address bits [2:0] come first, then data bits [17:0].
- `RB2_RW` out 1: RB2 control. 1 = read/idle, 0 = write.
- `RB2_A` out ADDR_W: RB2 address.
- `RB2_D` out DATA_W: RB2 write data.
- `S2_done` out 1: all eight addresses written. Sticky.
- `frame_err` out 1: one-cycle pulse on a malformed frame. Tied 0 without `S2_FRAME_CHECK_EN`.

## Operation
- Reset values: `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0, `frame_err`=0. Shift register, bit counter and written-mask are all 0. State is ARM.
- **ARM**: wait for `sen`=1, then go to IDLE. This prevents capturing a partial frame when reset is released mid-frame.
- **IDLE**: on `sen`=0, shift in `sd` with count=1 and go to SHIFT.
- **SHIFT**, while `sen`=0:
  - Left-shift: `shreg <= {shreg[FRAME_BITS-2:0], sd}`.
  - Increment count, saturating at FRAME_BITS+1.
- **SHIFT**, on `sen`=1: go to WRITE.
- **WRITE** (one cycle):
  - Drive `RB2_RW`=0, `RB2_A`=`shreg[20:18]`, `RB2_D`=`shreg[17:0]`.
  - Set `mask[RB2_A]`.
  - Clear count. Go to IDLE, or to DONE if mask becomes 8'hFF.
  - In all other cycles, `RB2_RW`=1; `RB2_A`/`RB2_D` hold their last values.
- **DONE**: `S2_done`=1. Further frames are ignored; no RB2 writes occur until reset.
- Duplicate address: RB2 is rewritten and the mask is unchanged.
- Addresses may arrive in any order.
- `sen` low in WRITE (back-to-back frame with a one-cycle gap):
  - WRITE completes as normal.
  - That cycle's `sd` is shifted in as bit 1 of the next frame, so no bit is lost.
  - The next state is SHIFT with count=1.
- Reset mid-frame or mid-write: all state and outputs return to reset values immediately; RB2 is not written.

## Timing
- Latency: the RB2 write strobe is asserted in the cycle after the first rising edge at which `sen`=1 is sampled following a frame.
- One write per frame. Minimum frame period is FRAME_BITS+1 = 22 cycles.
- Eight frames with one-cycle gaps: `S2_done` rises at the end of the 8th WRITE cycle, i.e. 8×22 cycles after the first `sen` fall.
- All outputs are registered.

## Configuration
- `S2_FRAME_CHECK_EN` defined:
  - In SHIFT→WRITE, a count ≠ FRAME_BITS (short frame, or a long frame where count saturated) suppresses the write.
  - `frame_err` pulses for one cycle instead, the mask is unchanged, and the FSM returns to IDLE.
- `S2_FRAME_CHECK_EN` undefined:
  - No length check; the last 21 bits shifted in are written.
  - A short frame writes with zero-filled leading bits.
  - `frame_err` is constant 0.

## Structure
- Shared package `s2_pkg`:
  - `FRAME_BITS`, `ADDR_W`, `DATA_W`, `NUM_WORDS`=8.
  - State enum `s2_state_t` {ARM, IDLE, SHIFT, WRITE, DONE}.
- Sub-module `s2_shift_rx`: shift register and saturating bit counter, with shift-enable and clear inputs. Outputs are `shreg` and `count`.
- The top level holds the FSM, the written-mask and the RB2 output registers.

## Test plan
- Frame addr=3'b101, data=18'h2A5C3 → exactly one cycle with `RB2_RW`=0, `RB2_A`=5, `RB2_D`=18'h2A5C3, in the cycle after `sen` rises.
- Eight frames for addresses 0..7, data=18'h00001<<addr, 1-cycle gaps → eight writes with matching data. `S2_done` goes to 1 after the 8th write and stays 1; a 9th frame produces no write.
- Address 2 sent twice (18'h3FFFF, then 18'h00000) plus the other seven addresses → the last write to address 2 carries 0, and `S2_done` rises only after all eight distinct addresses are written.
- With `S2_FRAME_CHECK_EN`:
  - A 15-bit frame → no write, one-cycle `frame_err`.
  - A following valid frame to addr=1 → written normally.
- Reset released while `sen`=0 mid-frame → no write for the partial frame; the next full frame is written correctly.
- `rst` asserted during SHIFT at bit 10 → all outputs at reset values, no write; a subsequent full frame is received correctly.
